// File: rtl/pc_gen.sv
// Program counter generator with RUN/FAULT misalignment FSM and optional return-address stack.
// Define PC_GEN_RAS_EN to build the return-address stack; otherwise ras_top/ras_valid read as zero.
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            pc_rst,
    input  logic            pc_we,
    input  logic [2:0]      pc_sel,
    input  logic [XLEN-1:0] jalr,
    input  logic [XLEN-1:0] branch,
    input  logic [XLEN-1:0] jal,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic            is_call,
    input  logic            is_ret,
    output logic [XLEN-1:0] pc_count,
    output logic [XLEN-1:0] next_addr,
    output logic            misalign,
    output logic [XLEN-1:0] bad_addr,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid
);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] target;
    logic            pc_load;
    logic            fault_now;

    assign next_addr = pc_count + XLEN'(4);

    // Trap vectors are force-aligned, so only sources 0-3 can ever fault.
    always_comb begin
        target = pc_count;
        case (pc_sel)
            3'd0:    target = next_addr;
            3'd1:    target = jalr;
            3'd2:    target = branch;
            3'd3:    target = jal;
            3'd4:    target = mtvec & ~XLEN'(3);
            3'd5:    target = mepc & ~XLEN'(3);
            default: target = pc_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pc_rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_load   = 1'b0;
        fault_now = 1'b0;
        case (state)
            RUN: begin
                if (pc_we) begin
                    if (pc_sel <= 3'd3) begin
                        if (target[1:0] == 2'b00) begin
                            pc_load = 1'b1;
                        end else begin
                            fault_now = 1'b1;
                            state_nxt = FAULT;
                        end
                    end else if (pc_sel <= 3'd5) begin
                        pc_load = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (pc_we && pc_sel == 3'd4) begin
                    pc_load   = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        misalign = (state == FAULT);
    end

    always_ff @(posedge clk) begin
        if (pc_rst) begin
            pc_count <= RESET_VEC;
            bad_addr <= '0;
        end else begin
            if (pc_load) begin
                pc_count <= target;
            end
            if (fault_now) begin
                bad_addr <= target;
            end
        end
    end

`ifdef PC_GEN_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] ras_ptr_inc;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_en;
    logic             ras_push;
    logic             ras_swap;
    logic             ras_pop;

    // Circular buffer: ras_ptr addresses the newest entry; a push on a full
    // stack wraps onto the oldest slot while the count saturates.
    assign ras_en      = pc_we && (state == RUN) && !fault_now;
    assign ras_ptr_inc = ras_ptr + PTR_W'(1);
    assign ras_push    = ras_en && is_call && (!is_ret || ras_cnt == '0);
    assign ras_swap    = ras_en && is_call && is_ret && (ras_cnt != '0);
    assign ras_pop     = ras_en && !is_call && is_ret && (ras_cnt != '0);

    always_ff @(posedge clk) begin
        if (pc_rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_ptr <= ras_ptr_inc;
            if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
                ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - PTR_W'(1);
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!pc_rst) begin
            if (ras_push) begin
                ras_mem[ras_ptr_inc] <= next_addr;
            end else if (ras_swap) begin
                ras_mem[ras_ptr] <= next_addr;
            end
        end
    end

    assign ras_valid = (ras_cnt != '0);
    assign ras_top   = ras_valid ? ras_mem[ras_ptr] : '0;
`else
    logic unused_ras_in;

    assign unused_ras_in = is_call ^ is_ret;
    assign ras_valid     = 1'b0;
    assign ras_top       = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic against a queue-based model.
// Follows PC_GEN_RAS_EN so the expected stack behaviour matches the build.
module tb_pc_gen;

    localparam logic [31:0] RV    = 32'h100;
    localparam int          DEPTH = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        pc_rst, pc_we, is_call, is_ret;
    logic [2:0]  pc_sel;
    logic [31:0] jalr, branch, jal, mtvec, mepc;
    logic [31:0] pc_count, next_addr, bad_addr, ras_top;
    logic        misalign, ras_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_bad;
    bit          m_fault;
    logic [31:0] m_ras[$];

    pc_gen #(.XLEN(32), .RESET_VEC(RV), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .pc_rst(pc_rst), .pc_we(pc_we), .pc_sel(pc_sel),
        .jalr(jalr), .branch(branch), .jal(jal), .mtvec(mtvec), .mepc(mepc),
        .is_call(is_call), .is_ret(is_ret),
        .pc_count(pc_count), .next_addr(next_addr), .misalign(misalign),
        .bad_addr(bad_addr), .ras_top(ras_top), .ras_valid(ras_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [31:0] na, tgt;
        bit          was_fault, faults;
        if (pc_rst) begin
            m_pc = RV; m_bad = 0; m_fault = 0; m_ras.delete();
            return;
        end
        na = m_pc + 32'd4;
        was_fault = m_fault;
        faults = 0;
        case (pc_sel)
            3'd0: tgt = na;
            3'd1: tgt = jalr;
            3'd2: tgt = branch;
            3'd3: tgt = jal;
            3'd4: tgt = (mtvec / 4) * 4;
            3'd5: tgt = (mepc / 4) * 4;
            default: tgt = m_pc;
        endcase
        if (was_fault) begin
            if (pc_we && pc_sel == 3'd4) begin
                m_pc = tgt; m_fault = 0;
            end
        end else if (pc_we && pc_sel <= 3'd5) begin
            if (pc_sel <= 3'd3 && (tgt % 4) != 0) begin
                faults = 1; m_fault = 1; m_bad = tgt;
            end else begin
                m_pc = tgt;
            end
        end
        if (RAS_EN && pc_we && !was_fault && !faults) begin
            if (is_call && is_ret) begin
                if (m_ras.size() == 0) m_ras.push_back(na);
                else m_ras[m_ras.size()-1] = na;
            end else if (is_call) begin
                m_ras.push_back(na);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (is_ret && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
    endtask

    task automatic compare_all();
        check("pc_count",  pc_count,  m_pc);
        check("next_addr", next_addr, m_pc + 32'd4);
        check("misalign",  {31'd0, misalign}, {31'd0, m_fault});
        check("bad_addr",  bad_addr,  m_bad);
        check("ras_valid", {31'd0, ras_valid}, (m_ras.size() > 0) ? 32'd1 : 32'd0);
        check("ras_top",   ras_top,   (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0);
    endtask

    task automatic step(input logic rst, input logic we, input logic [2:0] sel,
                        input logic [31:0] tgt, input logic call, input logic ret);
        pc_rst = rst; pc_we = we; pc_sel = sel; is_call = call; is_ret = ret;
        jalr = tgt; branch = tgt; jal = tgt; mtvec = tgt; mepc = tgt;
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    initial begin
        m_pc = RV; m_bad = 0; m_fault = 0;
        #1;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 3, 32'h55, 1, 1);
        check("reset_pc_const", pc_count, 32'h100);
        check("reset_next_const", next_addr, 32'h104);

        repeat (3) step(0, 1, 0, 0, 0, 0);
        check("seq_pc_const", pc_count, 32'h10C);

        step(0, 1, 1, 32'h202, 0, 0);
        check("fault_bad_const", bad_addr, 32'h202);
        step(0, 1, 3, 32'h300, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 4, 32'h801, 0, 0);
        check("mtvec_pc_const", pc_count, 32'h800);
        step(0, 1, 5, 32'h903, 0, 0);

        step(0, 1, 3, 32'hFFFF_FFFC, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("wrap_pc_const", pc_count, 32'h0);

        for (int i = 0; i < 5; i++) step(0, 1, 3, m_pc + 32'h10, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 6, 0, 0, 1);
        step(0, 1, 6, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 6, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 7, 0, 1, 0);
        step(0, 1, 2, 32'h41, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 6, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 9) < 8) t[1:0] = 2'b00;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) < 8),
                 3'($urandom_range(0, 7)), t,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
